// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a carry register and a Start/Busy/Done handshake.
// Shifts run one bit per cycle unless SEQ_ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module seq_alu #(
  parameter int W    = 8,
  parameter int OPS  = 4,
  parameter int IMMW = 5,
  parameter int SHW  = $clog2(W)
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [OPS-1:0]  OP,
  input  logic [W-1:0]    InputA,
  input  logic [W-1:0]    InputB,
  input  logic [IMMW-1:0] Immediate,
  output logic            Busy,
  output logic            Done,
  output logic [W-1:0]    Out,
  output logic            Carry,
  output logic            Zero,
  output logic            Parity,
  output logic            Odd,
  output logic            Illegal
);
  localparam logic [OPS-1:0] OP_ADD = OPS'(0);
  localparam logic [OPS-1:0] OP_ADC = OPS'(1);
  localparam logic [OPS-1:0] OP_SUB = OPS'(2);
  localparam logic [OPS-1:0] OP_LSL = OPS'(3);
  localparam logic [OPS-1:0] OP_LSR = OPS'(4);
  localparam logic [OPS-1:0] OP_ASR = OPS'(5);
  localparam logic [OPS-1:0] OP_ROL = OPS'(6);
  localparam logic [OPS-1:0] OP_XOR = OPS'(7);
  localparam logic [OPS-1:0] OP_MOV = OPS'(8);
  localparam logic [OPS-1:0] OP_SEQ = OPS'(9);
  localparam logic [OPS-1:0] OP_SNE = OPS'(10);
  localparam logic [OPS-1:0] OP_MSK = OPS'(11);

  // One-bit shift/rotate step; returns {bit shifted out, next value}.
  function automatic logic [W:0] step1(input logic [OPS-1:0] op, input logic [W-1:0] v);
    logic signed [W-1:0] sv;
    logic [W:0]          r;
    sv = $signed(v);
    case (op)
      OP_LSL:  r = {v[W-1], v << 1};
      OP_LSR:  r = {v[0], v >> 1};
      OP_ASR:  r = {v[0], W'(sv >>> 1)};
      OP_ROL:  r = {v[W-1], v[W-2:0], v[W-1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

`ifdef SEQ_ALU_BARREL_SHIFT_EN
  function automatic logic [W:0] shift_n(input logic [OPS-1:0] op, input logic [W-1:0] v,
                                         input logic [SHW-1:0] amt);
    logic [W:0]   r;
    logic [W-1:0] cur;
    logic         co_b;
    cur  = v;
    co_b = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(amt)) begin
        r    = step1(op, cur);
        co_b = r[W];
        cur  = r[W-1:0];
      end
    end
    return {co_b, cur};
  endfunction
`endif

  logic [W-1:0]   imm_ext;
  logic [SHW-1:0] k;
  logic [W-1:0]   out_q;
  logic           carry_q, done_q, illegal_q;
  logic [W-1:0]   res;
  logic           co, illegal_c;
  logic [W:0]     sum;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
  logic [W:0]     sh;
`endif

  assign imm_ext = W'(Immediate);
  assign k       = imm_ext[SHW-1:0];

  always_comb begin
    res       = out_q;
    co        = carry_q;
    illegal_c = 1'b0;
    sum       = '0;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
    sh        = '0;
`endif
    case (OP)
      OP_ADD: begin
        sum = {1'b0, InputA} + {1'b0, imm_ext};
        res = sum[W-1:0];
        co  = sum[W];
      end
      OP_ADC: begin
        sum = {1'b0, InputA} + {1'b0, InputB} + (W+1)'(carry_q);
        res = sum[W-1:0];
        co  = sum[W];
      end
      OP_SUB: begin
        sum = {1'b0, InputA} - {1'b0, InputB};
        res = sum[W-1:0];
        co  = ~sum[W];
      end
      OP_LSL, OP_LSR, OP_ASR, OP_ROL: begin
`ifdef SEQ_ALU_BARREL_SHIFT_EN
        sh  = shift_n(OP, InputA, k);
        res = sh[W-1:0];
        if (k != '0) co = sh[W];
`else
        res = InputA;
`endif
      end
      OP_XOR:  res = InputA ^ InputB;
      OP_MOV:  res = InputB;
      OP_SEQ:  res = W'(InputA == imm_ext);
      OP_SNE:  res = W'(InputA != imm_ext);
      OP_MSK:  res = W'(1) << InputB[SHW-1:0];
      default: illegal_c = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_BARREL_SHIFT_EN
  assign Busy = 1'b0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q     <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= Start;
      if (Start) begin
        out_q     <= res;
        carry_q   <= co;
        illegal_q <= illegal_c;
      end
    end
  end
`else
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q;
  logic [SHW-1:0] cnt_q;
  logic [OPS-1:0] shop_q;
  logic [W-1:0]   work_q;
  logic           busy_q;
  logic [W:0]     step;
  logic           is_shift;

  assign is_shift = OP inside {OP_LSL, OP_LSR, OP_ASR, OP_ROL};
  assign step     = step1(shop_q, work_q);
  assign Busy     = busy_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      shop_q    <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (Start) begin
          if (is_shift && k != '0) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= k;
            shop_q  <= OP;
          end else begin
            out_q     <= res;
            carry_q   <= co;
            illegal_q <= illegal_c;
            done_q    <= 1'b1;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            out_q     <= step[W-1:0];
            carry_q   <= step[W];
            illegal_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Working register: tracks A while idle so a shift starts from the latched operand.
  always_ff @(posedge Clk) begin
    if (state_q == IDLE) work_q <= InputA;
    else                 work_q <= step[W-1:0];
  end
`endif

  assign Out     = out_q;
  assign Carry   = carry_q;
  assign Done    = done_q;
  assign Illegal = illegal_q;
  assign Zero    = ~|out_q;
  assign Parity  = ^out_q;
  assign Odd     = out_q[0];
endmodule
